unidad_de_busqueda: RTL

Instruction fetch/decode stage directly upstream of the jump unit (Unidad_de_Saltos) in the 8-bit UAZ micro. It takes the instruction address the jump unit puts on its bus and fetches a 16-bit word from instruction memory using a variable-latency request/valid handshake. It decodes the word and drives back Direccion_de_Salto and Condicion, plus a PC-advance strobe. Non-jump fields go to the execute stage.

---
 rtl/unidad_de_busqueda.sv | 121 ++++++++++++
 1 files changed

// File: rtl/unidad_de_busqueda.sv
// Fetch/decode stage feeding the UAZ jump unit: fetches a 16-bit word over a
// variable-latency request/valid handshake, decodes it and strobes the PC advance.
module unidad_de_busqueda #(
    parameter logic [3:0]  OPCODE_SALTO  = 4'hF,
    parameter int unsigned TIEMPO_LIMITE = 15,
    parameter logic [15:0] INSTR_NOP     = 16'h0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  i_Bus_Direcciones_Instrucciones,
    output logic [7:0]  o_Mem_Direccion,
    output logic        o_Mem_Lectura,
    input  logic [15:0] i_Mem_Dato,
    input  logic        i_Mem_Valido,
    input  logic        i_Detener,
    output logic        o_Avanzar_PC,
    output logic [7:0]  Direccion_de_Salto,
    output logic [3:0]  Condicion,
    output logic [3:0]  o_Opcode,
    output logic [3:0]  o_Registro,
    output logic [7:0]  o_Inmediato,
    output logic        o_Instruccion_Valida,
    output logic        o_Error_Tiempo
);

    localparam logic [1:0] SOLICITAR   = 2'd0;
    localparam logic [1:0] ESPERAR     = 2'd1;
    localparam logic [1:0] DECODIFICAR = 2'd2;
    localparam logic [7:0] LIMITE      = TIEMPO_LIMITE[7:0];

    logic [1:0]  estado_q,   estado_d;
    logic [7:0]  dir_q,      dir_d;
    logic        lectura_q,  lectura_d;
    logic [7:0]  cnt_q,      cnt_d;
    logic [15:0] ir_q,       ir_d;
    logic        cargado_q,  cargado_d;
    logic        avanzar_q,  avanzar_d;
    logic [3:0]  cond_q,     cond_d;
    logic        error_q,    error_d;

    always_comb begin
        estado_d  = estado_q;
        dir_d     = dir_q;
        lectura_d = lectura_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        cargado_d = cargado_q;
        avanzar_d = 1'b0;
        cond_d    = 4'b0000;
        error_d   = error_q;
        case (estado_q)
            SOLICITAR: begin
                dir_d     = i_Bus_Direcciones_Instrucciones;
                lectura_d = 1'b1;
                cnt_d     = 8'd0;
                estado_d  = ESPERAR;
            end
            ESPERAR: begin
                cnt_d = cnt_q + 8'd1;
                // A valid word in the timeout cycle still counts as a normal fetch.
                if (i_Mem_Valido) begin
                    ir_d      = i_Mem_Dato;
                    lectura_d = 1'b0;
                    cargado_d = 1'b1;
                    estado_d  = DECODIFICAR;
                end else if (cnt_d == LIMITE) begin
                    ir_d      = INSTR_NOP;
                    error_d   = 1'b1;
                    lectura_d = 1'b0;
                    cargado_d = 1'b1;
                    estado_d  = DECODIFICAR;
                end
            end
            DECODIFICAR: begin
                if (!i_Detener) begin
                    avanzar_d = 1'b1;
                    cond_d    = (ir_q[15:12] == OPCODE_SALTO) ? {1'b1, ir_q[10:8]} : 4'b0000;
                    estado_d  = SOLICITAR;
                end
            end
            default: estado_d = SOLICITAR;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            estado_q  <= SOLICITAR;
            dir_q     <= 8'd0;
            lectura_q <= 1'b0;
            cnt_q     <= 8'd0;
            ir_q      <= INSTR_NOP;
            cargado_q <= 1'b0;
            avanzar_q <= 1'b0;
            cond_q    <= 4'b0000;
            error_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            dir_q     <= dir_d;
            lectura_q <= lectura_d;
            cnt_q     <= cnt_d;
            ir_q      <= ir_d;
            cargado_q <= cargado_d;
            avanzar_q <= avanzar_d;
            cond_q    <= cond_d;
            error_q   <= error_d;
        end
    end

    // Decoded fields read zero until the first word has been captured after reset.
    assign o_Opcode             = cargado_q ? ir_q[15:12] : 4'd0;
    assign o_Registro           = cargado_q ? ir_q[11:8]  : 4'd0;
    assign o_Inmediato          = cargado_q ? ir_q[7:0]   : 8'd0;
    assign Direccion_de_Salto   = cargado_q ? ir_q[7:0]   : 8'd0;
    assign o_Mem_Direccion      = dir_q;
    assign o_Mem_Lectura        = lectura_q;
    assign o_Avanzar_PC         = avanzar_q;
    assign Condicion            = cond_q;
    assign o_Instruccion_Valida = (estado_q == DECODIFICAR);
    assign o_Error_Tiempo       = error_q;

endmodule
